// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the interval-timer arbiter: FSM encoding and
// round-robin pointer sizing/reset value.
package timer_arbiter_pkg;

  // Widest supported requester set and the pointer width that covers it.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reset value of the round-robin pointer: the last requester, so that
  // the search after reset begins at requester 0.
  function automatic logic [IDX_W-1:0] last_granted_reset(input int n_req);
    return IDX_W'(n_req - 1);
  endfunction

endpackage

// File: rtl/timer_arbiter_interval_counter.sv
// Interval counter: loads a limit (zero treated as one), counts up when
// enabled, and flags the terminal count one below the limit. It never
// advances past the terminal value on its own; the owner clears it.
module interval_counter
  import timer_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_len,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] limit_r;

  // Count and limit registers; reset dominates, then load, clear, enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= {WIDTH{1'b0}};
      limit_r <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (load) begin
      count   <= {WIDTH{1'b0}};
      limit_r <= (load_len == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : load_len;
    end else if (clear) begin
      count   <= {WIDTH{1'b0}};
      limit_r <= limit_r;
    end else if (enable) begin
      count   <= count + {{(WIDTH-1){1'b0}}, 1'b1};
      limit_r <= limit_r;
    end else begin
      count   <= count;
      limit_r <= limit_r;
    end
  end

  // Terminal count: the last cycle of an interval of limit_r cycles.
  always_comb begin
    tc = (count == (limit_r - {{(WIDTH-1){1'b0}}, 1'b1}));
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting a shared interval counter to one of N_REQ
// requesters at a time. A grant runs for the requester's latched length,
// ends with a one-cycle done pulse, or is abandoned when the request drops.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  localparam logic [IDX_W-1:0] LAST_RESET = last_granted_reset(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT_0  = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] last_next_s;
  logic [N_REQ-1:0] grant_next_s;
  logic [N_REQ-1:0] done_next_s;
  logic             busy_next_s;

  logic             sel_found_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [WIDTH-1:0] sel_len_s;
  int               cand_s;

  logic             cnt_clear_s;
  logic             cnt_load_s;
  logic             cnt_enable_s;
  logic             cnt_tc_s;
  logic             owner_req_s;

  interval_counter #(
    .WIDTH(WIDTH)
  ) u_interval_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .load     (cnt_load_s),
    .load_len (sel_len_s),
    .enable   (cnt_enable_s),
    .count    (count),
    .tc       (cnt_tc_s)
  );

  // Round-robin pick: first asserted request after the last grant, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    sel_len_s   = {WIDTH{1'b0}};
    cand_s      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      if ((int'(last_r) + k) >= N_REQ) begin
        cand_s = int'(last_r) + k - N_REQ;
      end else begin
        cand_s = int'(last_r) + k;
      end
      if (!sel_found_s && ((req & (ONE_HOT_0 << cand_s)) != {N_REQ{1'b0}})) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(cand_s);
        sel_len_s   = len[cand_s*WIDTH +: WIDTH];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // The granted requester still holds its request (grant is one-hot).
  always_comb begin
    owner_req_s = ((req & grant) != {N_REQ{1'b0}});
  end

  // Next-state, next-output and counter control; abort beats terminal count.
  always_comb begin
    state_next_s = state_r;
    grant_next_s = grant;
    done_next_s  = {N_REQ{1'b0}};
    last_next_s  = last_r;
    cnt_clear_s  = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_enable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_next_s = ST_RUN;
          grant_next_s = ONE_HOT_0 << sel_idx_s;
          last_next_s  = sel_idx_s;
          cnt_load_s   = 1'b1;
        end else begin
          grant_next_s = {N_REQ{1'b0}};
          cnt_clear_s  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!owner_req_s) begin
          state_next_s = ST_IDLE;
          grant_next_s = {N_REQ{1'b0}};
          cnt_clear_s  = 1'b1;
        end else if (cnt_tc_s) begin
          state_next_s = ST_DONE;
          grant_next_s = {N_REQ{1'b0}};
          done_next_s  = grant;
          cnt_clear_s  = 1'b1;
        end else begin
          cnt_enable_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        grant_next_s = {N_REQ{1'b0}};
        cnt_clear_s  = 1'b1;
      end
      default: begin
        state_next_s = ST_IDLE;
        grant_next_s = {N_REQ{1'b0}};
        cnt_clear_s  = 1'b1;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State and registered outputs; synchronous reset takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant   <= {N_REQ{1'b0}};
      done    <= {N_REQ{1'b0}};
      busy    <= 1'b0;
      last_r  <= LAST_RESET;
    end else begin
      state_r <= state_next_s;
      grant   <= grant_next_s;
      done    <= done_next_s;
      busy    <= busy_next_s;
      last_r  <= last_next_s;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] len = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int tests = 0;
  int fails = 0;

  timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: who owns the counter, how far along, and who just finished.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_lim   = 1;
  int m_done  = -1;
  int m_last  = N - 1;

  always @(posedge clk) begin
    int w;
    int lv;
    bit found;
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_done = -1; m_last = N - 1;
    end else if (m_owner >= 0) begin
      m_done = -1;
      if (((req >> m_owner) & 4'b0001) == 4'b0000) begin
        m_owner = -1; m_cnt = 0;
      end else if (m_cnt == m_lim - 1) begin
        m_done = m_owner; m_owner = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_done >= 0) begin
      m_done = -1;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        w = (m_last + k) % N;
        if (!found && (((req >> w) & 4'b0001) != 4'b0000)) begin
          found = 1'b1;
          m_owner = w; m_last = w; m_cnt = 0;
          lv = int'(len[w*W +: W]);
          m_lim = (lv == 0) ? 1 : lv;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("cyc_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("cyc_done",  32'(done),  (m_done  >= 0) ? (32'd1 << m_done)  : 32'd0);
    chk("cyc_count", 32'(count), (m_owner >= 0) ? 32'(m_cnt) : 32'd0);
    chk("cyc_busy",  32'(busy),  ((m_owner >= 0) || (m_done >= 0)) ? 32'd1 : 32'd0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic wait_cnt(input int val, input int bound, input string name);
    int n;
    n = 0;
    while ((int'(count) != val) && (n < bound)) begin
      step();
      n++;
    end
    chk(name, 32'(count), 32'(val));
  endtask

  task automatic measure(output int cyc, output int mx);
    int n;
    n = 0;
    while ((grant == '0) && (n < 5)) begin
      step();
      n++;
    end
    cyc = 0;
    mx = 0;
    while ((grant != '0) && (cyc < 400)) begin
      cyc++;
      if (int'(count) > mx) mx = int'(count);
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] glog[$];
    int           tlog[$];
    int           cyc;
    int           mx;

    // Reset state.
    reset = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    reset = 1'b0;

    // Single requester, len=3.
    set_len(0, 3);
    req = 4'b0001;
    step();
    chk("s1_grant", 32'(grant), 32'd1);
    chk("s1_cnt0",  32'(count), 32'd0);
    chk("s1_busy",  32'(busy),  32'd1);
    step();
    chk("s1_cnt1",  32'(count), 32'd1);
    step();
    chk("s1_cnt2",  32'(count), 32'd2);
    step();
    chk("s1_done",  32'(done),  32'd1);
    chk("s1_gclr",  32'(grant), 32'd0);
    req = 4'b0000;
    step();
    chk("s1_done_clr", 32'(done), 32'd0);
    chk("s1_idle",     32'(busy), 32'd0);

    // Round-robin order with all requesters and len=1.
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      if ((grant != '0) && (prev == '0)) begin
        glog.push_back(grant);
        tlog.push_back(c);
      end
      prev = grant;
    end
    req = 4'b0000;
    chk("rr_n", 32'(glog.size()), 32'd6);
    chk("rr_g0", 32'(glog[0]), 32'd1);
    chk("rr_g1", 32'(glog[1]), 32'd2);
    chk("rr_g2", 32'(glog[2]), 32'd4);
    chk("rr_g3", 32'(glog[3]), 32'd8);
    chk("rr_g4", 32'(glog[4]), 32'd1);
    for (int i = 1; i < 5; i++) chk("rr_gap", 32'(tlog[i] - tlog[i-1]), 32'd3);
    step();
    step();

    // Abort of requester 2 at count 4; next search starts at 3.
    do_reset();
    set_len(2, 10);
    set_len(3, 2);
    req = 4'b0100;
    step();
    chk("ab_grant", 32'(grant), 32'd4);
    wait_cnt(4, 20, "ab_wait4");
    req = 4'b1001;
    step();
    chk("ab_gclr", 32'(grant), 32'd0);
    chk("ab_nodone", 32'(done), 32'd0);
    chk("ab_cnt", 32'(count), 32'd0);
    step();
    chk("ab_next_rr", 32'(grant), 32'd8);
    req = 4'b0000;
    step();
    step();
    step();

    // len=0 lasts one cycle, len=255 lasts 255 cycles without wrapping.
    do_reset();
    set_len(0, 0);
    req = 4'b0001;
    measure(cyc, mx);
    chk("len0_cycles", 32'(cyc), 32'd1);
    req = 4'b0000;
    step();
    step();
    set_len(0, 255);
    req = 4'b0001;
    measure(cyc, mx);
    chk("len255_cycles", 32'(cyc), 32'd255);
    chk("len255_max", 32'(mx), 32'd254);
    req = 4'b0000;
    step();
    step();

    // Reset mid-interval.
    do_reset();
    set_len(0, 20);
    req = 4'b0001;
    step();
    wait_cnt(5, 30, "mr_wait5");
    reset = 1'b1;
    step();
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_done",  32'(done),  32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_busy",  32'(busy),  32'd0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 2);
    req = 4'b1111;
    step();
    chk("mr_regrant", 32'(grant), 32'd1);
    req = 4'b0000;
    step();
    step();

    // len change during RUN is ignored; abort on terminal cycle gives no done.
    do_reset();
    set_len(0, 4);
    req = 4'b0001;
    step();
    set_len(0, 9);
    measure(cyc, mx);
    chk("lenchg_cycles", 32'(cyc), 32'd4);
    req = 4'b0000;
    step();
    step();
    set_len(1, 3);
    req = 4'b0010;
    step();
    chk("tcab_grant", 32'(grant), 32'd2);
    wait_cnt(2, 10, "tcab_wait2");
    req = 4'b0000;
    step();
    chk("tcab_nodone", 32'(done), 32'd0);
    chk("tcab_gclr",   32'(grant), 32'd0);
    step();
    chk("tcab_nodone2", 32'(done), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
